// File: rtl/stream_arb2.sv
// Two-port frame arbiter: locks the downstream stream to one upstream port for a whole frame.
// Optional round-robin tie-breaking is enabled by defining STREAM_ARB_RR_EN (default: port 0 wins ties).
module stream_arb2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] uc0_d0,
  input  logic [3:0]   uc0_mflags,
  output logic [1:0]   cu0_sflags,
  input  logic [W-1:0] uc1_d0,
  input  logic [3:0]   uc1_mflags,
  output logic [1:0]   cu1_sflags,
  output logic [W-1:0] cd_d0,
  output logic [3:0]   cd_mflags,
  input  logic [1:0]   dc_sflags,
  output logic [1:0]   gnt,
  output logic [1:0]   err_drop
);

  localparam int VLD   = 0;
  localparam int LAST  = 1;
  localparam int FIRST = 2;
  localparam int AGAIN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOCK0 = 2'b01,
    ST_LOCK1 = 2'b10
  } state_t;

  state_t     state;
  logic [1:0] req;
  logic [1:0] drop;
  logic [3:0] own_mflags;
  logic       release_lock;
  logic       tie_pick1;

  // A frame opener requests; a stray mid-frame beat while idle is swallowed and flagged.
  assign req[0]  = uc0_mflags[VLD] & uc0_mflags[FIRST] & ~uc0_mflags[AGAIN];
  assign req[1]  = uc1_mflags[VLD] & uc1_mflags[FIRST] & ~uc1_mflags[AGAIN];
  assign drop[0] = uc0_mflags[VLD] & ~uc0_mflags[FIRST] & ~uc0_mflags[AGAIN];
  assign drop[1] = uc1_mflags[VLD] & ~uc1_mflags[FIRST] & ~uc1_mflags[AGAIN];

  assign own_mflags   = (state == ST_LOCK1) ? uc1_mflags : uc0_mflags;
  assign release_lock = ((state == ST_LOCK0) || (state == ST_LOCK1)) &&
                        (dc_sflags[1] ||
                         (own_mflags[VLD] && !own_mflags[AGAIN] && !dc_sflags[0] && own_mflags[LAST]));

`ifdef STREAM_ARB_RR_EN
  logic rr_ptr;
  assign tie_pick1 = rr_ptr;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= 2'b00;
      err_drop <= 2'b00;
`ifdef STREAM_ARB_RR_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      err_drop <= 2'b00;
      case (state)
        ST_IDLE: begin
          err_drop <= drop;
          if ((req[1] && !req[0]) || (req == 2'b11 && tie_pick1)) begin
            state <= ST_LOCK1;
            gnt   <= 2'b10;
          end else if (req[0]) begin
            state <= ST_LOCK0;
            gnt   <= 2'b01;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (release_lock) begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
`ifdef STREAM_ARB_RR_EN
            rr_ptr <= (state == ST_LOCK0);
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Locked: straight-through mux. Otherwise hold everyone off except beats being dropped.
  always_comb begin
    cd_d0      = '0;
    cd_mflags  = 4'b0000;
    cu0_sflags = 2'b01;
    cu1_sflags = 2'b01;
    case (state)
      ST_LOCK0: begin
        cd_d0      = uc0_d0;
        cd_mflags  = uc0_mflags;
        cu0_sflags = dc_sflags;
      end
      ST_LOCK1: begin
        cd_d0      = uc1_d0;
        cd_mflags  = uc1_mflags;
        cu1_sflags = dc_sflags;
      end
      ST_IDLE: begin
        if (drop[0]) cu0_sflags = 2'b00;
        if (drop[1]) cu1_sflags = 2'b00;
      end
      default: begin
        cd_d0 = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_arb2.sv
// Directed self-checking bench for stream_arb2; expected grant order follows STREAM_ARB_RR_EN.
module tb_stream_arb2;

  localparam logic [3:0] MF_NONE   = 4'b0000;
  localparam logic [3:0] MF_FIRST  = 4'b0101;
  localparam logic [3:0] MF_MID    = 4'b0001;
  localparam logic [3:0] MF_LAST   = 4'b0011;
  localparam logic [3:0] MF_SINGLE = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] uc0_d0 = '0, uc1_d0 = '0, cd_d0;
  logic [3:0]  uc0_mflags = '0, uc1_mflags = '0, cd_mflags;
  logic [1:0]  cu0_sflags, cu1_sflags, dc_sflags = 2'b00, gnt, err_drop;

  int checks = 0;
  int errors = 0;

  stream_arb2 #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .uc0_d0(uc0_d0), .uc0_mflags(uc0_mflags), .cu0_sflags(cu0_sflags),
    .uc1_d0(uc1_d0), .uc1_mflags(uc1_mflags), .cu1_sflags(cu1_sflags),
    .cd_d0(cd_d0), .cd_mflags(cd_mflags), .dc_sflags(dc_sflags),
    .gnt(gnt), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [31:0] d, input logic [3:0] mf);
    if (p == 0) begin
      uc0_d0 = d; uc0_mflags = mf;
    end else begin
      uc1_d0 = d; uc1_mflags = mf;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, MF_NONE);
    applyStimulus(1, 0, MF_NONE);
    dc_sflags = 2'b00;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int win;
    int fr [2];

    // Reset state
    #2;
    checkOutput("rst_gnt", gnt, 2'b00);
    checkOutput("rst_err", err_drop, 2'b00);
    checkOutput("rst_cdmf", cd_mflags, MF_NONE);
    tick();
    rst_n = 1'b1;
    #1;

    // Scenario 1: 3-beat frame on port 0
    applyStimulus(0, 5, MF_FIRST);
    checkOutput("s1_stall", cu0_sflags, 2'b01);
    checkOutput("s1_idle_cd", cd_mflags, MF_NONE);
    tick();
    checkOutput("s1_gnt", gnt, 2'b01);
    checkOutput("s1_d5", cd_d0, 5);
    checkOutput("s1_mf5", cd_mflags, MF_FIRST);
    checkOutput("s1_ready", cu0_sflags, 2'b00);
    tick();
    applyStimulus(0, 6, MF_MID);
    checkOutput("s1_d6", cd_d0, 6);
    tick();
    applyStimulus(0, 7, MF_LAST);
    checkOutput("s1_d7", cd_d0, 7);
    checkOutput("s1_mf7", cd_mflags, MF_LAST);
    tick();
    applyStimulus(0, 0, MF_NONE);
    checkOutput("s1_release", gnt, 2'b00);

    // Scenario 2: both ports hold 2-beat frames, 4 frames
    doReset();
    fr[0] = 0; fr[1] = 0;
    for (int f = 0; f < 4; f++) begin
`ifdef STREAM_ARB_RR_EN
      win = f % 2;
`else
      win = 0;
`endif
      applyStimulus(0, 32'h100 + fr[0] * 2, MF_FIRST);
      applyStimulus(1, 32'h200 + fr[1] * 2, MF_FIRST);
      checkOutput("s2_idle_gnt", gnt, 2'b00);
      tick();
      checkOutput("s2_gnt", gnt, (win == 0) ? 2'b01 : 2'b10);
      checkOutput("s2_first", cd_d0, ((win == 0) ? 32'h100 : 32'h200) + fr[win] * 2);
      tick();
      applyStimulus(win, ((win == 0) ? 32'h100 : 32'h200) + fr[win] * 2 + 1, MF_LAST);
      checkOutput("s2_last", cd_d0, ((win == 0) ? 32'h100 : 32'h200) + fr[win] * 2 + 1);
      checkOutput("s2_loser_bsy", (win == 0) ? cu1_sflags : cu0_sflags, 2'b01);
      tick();
      fr[win]++;
    end
    applyStimulus(0, 0, MF_NONE);
    applyStimulus(1, 0, MF_NONE);
    tick();

    // Scenario 3: downstream back-pressure mid-frame
    applyStimulus(0, 10, MF_FIRST);
    tick();
    checkOutput("s3_d10", cd_d0, 10);
    tick();
    applyStimulus(0, 11, MF_MID);
    dc_sflags = 2'b01;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("s3_hold", cd_d0, 11);
      checkOutput("s3_bsy", cu0_sflags, 2'b01);
      tick();
    end
    dc_sflags = 2'b00;
    #1;
    checkOutput("s3_d11", cd_d0, 11);
    tick();
    applyStimulus(0, 12, MF_MID);
    checkOutput("s3_d12", cd_d0, 12);
    tick();
    applyStimulus(0, 13, MF_LAST);
    checkOutput("s3_d13", cd_d0, 13);
    tick();
    applyStimulus(0, 0, MF_NONE);
    checkOutput("s3_release", gnt, 2'b00);

    // Scenario 4: abort on beat 2 of a port 1 frame, port 0 waiting
    applyStimulus(1, 20, MF_FIRST);
    tick();
    checkOutput("s4_gnt1", gnt, 2'b10);
    applyStimulus(0, 30, MF_SINGLE);
    checkOutput("s4_p0_stall", cu0_sflags, 2'b01);
    tick();
    applyStimulus(1, 21, MF_MID);
    dc_sflags = 2'b10;
    #1;
    checkOutput("s4_abt1", cu1_sflags, 2'b10);
    checkOutput("s4_abt0", cu0_sflags, 2'b01);
    tick();
    dc_sflags = 2'b00;
    applyStimulus(1, 0, MF_NONE);
    checkOutput("s4_idle", gnt, 2'b00);
    checkOutput("s4_idle_cd", cd_mflags, MF_NONE);
    tick();
    checkOutput("s4_gnt0", gnt, 2'b01);
    checkOutput("s4_d30", cd_d0, 30);
    tick();
    applyStimulus(0, 0, MF_NONE);
    checkOutput("s4_release", gnt, 2'b00);

    // Scenario 5: stray mid-frame beat on port 1 while idle
    applyStimulus(1, 32'h55, MF_MID);
    checkOutput("s5_consume", cu1_sflags, 2'b00);
    checkOutput("s5_cdmf", cd_mflags, MF_NONE);
    checkOutput("s5_err_pre", err_drop, 2'b00);
    tick();
    applyStimulus(1, 0, MF_NONE);
    checkOutput("s5_err", err_drop, 2'b10);
    checkOutput("s5_cdmf2", cd_mflags, MF_NONE);
    tick();
    checkOutput("s5_err_end", err_drop, 2'b00);

    // Scenario 6: reset mid-frame
    applyStimulus(0, 40, MF_FIRST);
    tick();
    tick();
    applyStimulus(0, 41, MF_MID);
    checkOutput("s6_locked", gnt, 2'b01);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_gnt", gnt, 2'b00);
    checkOutput("s6_rst_cdmf", cd_mflags, MF_NONE);
    applyStimulus(0, 0, MF_NONE);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 50, MF_SINGLE);
    tick();
    checkOutput("s6_gnt", gnt, 2'b01);
    checkOutput("s6_d50", cd_d0, 50);
    checkOutput("s6_mf50", cd_mflags, MF_SINGLE);
    tick();
    applyStimulus(0, 0, MF_NONE);
    checkOutput("s6_release", gnt, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
